// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin arbiter feeding bytes from N_REQ requesters    |
// | into a single UART transmitter. UART_ARB_LOCK_EN enables packet lock.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [8*N_REQ-1:0] data_i,
   input  logic [N_REQ-1:0]   last_i,
   input  logic               tx_busy_i,
   output logic [N_REQ-1:0]   ack_o,
   output logic               tx_start_o,
   output logic [7:0]         tx_data_o,
   output logic [IDX_W-1:0]   owner_o,
   output logic               arb_busy_o
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   owner_q;
   logic [7:0]         tx_data_q;
   logic               tx_start_q;
   logic [N_REQ-1:0]   ack_q;
   logic               arb_busy_q;

   logic [7:0]         byte_w [N_REQ];
   logic               rr_found;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W-1:0]   cand;
   logic               grant_found;
   logic [IDX_W-1:0]   grant_idx;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base,
                                                 input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return sum[IDX_W-1:0];
   endfunction

   generate
      for (genvar g = 0; g < N_REQ; g++) begin : g_byte
         assign byte_w[g] = data_i[8*g +: 8];
      end
   endgenerate

`ifdef UART_ARB_LOCK_EN
   logic lock_q;
`else
   logic unused_last;
   assign unused_last = ^last_i;
`endif

   // Scan from the farthest offset down so the nearest requester at/after ptr wins.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = ptr_q;
      cand     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = wrap_inc(ptr_q, k);
         if (req_i[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
`ifdef UART_ARB_LOCK_EN
      grant_found = lock_q ? req_i[owner_q] : rr_found;
      grant_idx   = lock_q ? owner_q : rr_idx;
`else
      grant_found = rr_found;
      grant_idx   = rr_idx;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (grant_found && !tx_busy_i) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: if (tx_busy_i) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (!tx_busy_i) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         ack_q      <= '0;
         arb_busy_q <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         arb_busy_q <= (state_d != S_IDLE);
         tx_start_q <= 1'b0;
         ack_q      <= '0;
         case (state_q)
            S_IDLE: begin
               if (state_d == S_ISSUE) begin
                  tx_start_q <= 1'b1;
                  ack_q      <= N_REQ'(1) << grant_idx;
                  owner_q    <= grant_idx;
                  tx_data_q  <= byte_w[grant_idx];
`ifdef UART_ARB_LOCK_EN
                  lock_q     <= !last_i[grant_idx];
`endif
               end
`ifdef UART_ARB_LOCK_EN
               // Owner abandoned its packet: release and resume after it.
               else if (lock_q && !req_i[owner_q]) begin
                  lock_q <= 1'b0;
                  ptr_q  <= wrap_inc(owner_q, 1);
               end
`endif
            end
            S_WAIT_DONE: begin
`ifdef UART_ARB_LOCK_EN
               if (state_d == S_IDLE && !lock_q) ptr_q <= wrap_inc(owner_q, 1);
`else
               if (state_d == S_IDLE) ptr_q <= wrap_inc(owner_q, 1);
`endif
            end
            default: ;
         endcase
      end
   end

   assign ack_o      = ack_q;
   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;
   assign owner_o    = owner_q;
   assign arb_busy_o = arb_busy_q;

endmodule
`default_nettype wire
